// File: rtl/picosoc_bus_arbiter.sv
// Two-master round-robin arbiter for the PicoSoC native memory bus.
// Each granted transaction is guarded by a watchdog that force-completes it with an error.
module picosoc_bus_arbiter #(
  parameter int          TIMEOUT   = 64,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic        owner,
  output logic        timeout_err
);

  // state | meaning
  // IDLE  | waiting for a request; arbitrates on the next edge
  // BUSY  | slave request presented for owner, watchdog running
  // DONE  | one-cycle gap so the finished master can drop valid
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int              WW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0]   WDOG_LAST = WW'(TIMEOUT - 1);

  state_t        state;
  logic [WW-1:0] wdog;
  logic          busy;
  logic          own_valid;
  logic          finish;
  logic [31:0]   rdata_sel;

  assign busy      = (state == BUSY);
  assign own_valid = owner ? m1_valid : m0_valid;
  // s_ready takes priority over the watchdog in the same cycle
  assign finish    = busy && own_valid && (s_ready || (wdog == WDOG_LAST));
  assign rdata_sel = s_ready ? s_rdata : ERR_RDATA;

  assign m0_ready    = finish && !owner;
  assign m1_ready    = finish && owner;
  assign m0_rdata    = m0_ready ? rdata_sel : 32'h0;
  assign m1_rdata    = m1_ready ? rdata_sel : 32'h0;
  assign timeout_err = finish && !s_ready;

  assign s_addr  = owner ? m1_addr : m0_addr;
  assign s_wdata = owner ? m1_wdata : m0_wdata;
  assign s_wstrb = busy ? (owner ? m1_wstrb : m0_wstrb) : 4'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= 1'b1;
      wdog    <= '0;
      s_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_valid || m1_valid) begin
            // both requesting: flip from the last grant; otherwise grant the lone requester
            owner   <= (m0_valid && m1_valid) ? ~owner : m1_valid;
            state   <= BUSY;
            s_valid <= 1'b1;
            wdog    <= '0;
          end
        end
        BUSY: begin
          if (!own_valid) begin
            state   <= IDLE;
            s_valid <= 1'b0;
          end else if (finish) begin
            state   <= DONE;
            s_valid <= 1'b0;
          end else begin
            wdog <= wdog + WW'(1);
          end
        end
        DONE: state <= IDLE;
        default: begin
          state   <= IDLE;
          s_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_picosoc_bus_arbiter.sv
// Bench for picosoc_bus_arbiter: constant vector table, directed corner sequences,
// and random traffic checked every cycle against a transaction-level model.
module tb_picosoc_bus_arbiter;

  localparam int          TIMEOUT = 64;
  localparam logic [31:0] ERR     = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m1_valid, m0_ready, m1_ready;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        s_valid, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        owner, timeout_err;

  always #5 clk = ~clk;

  picosoc_bus_arbiter #(.TIMEOUT(TIMEOUT), .ERR_RDATA(ERR)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .owner(owner), .timeout_err(timeout_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which phase of a transaction we are in, who holds the bus,
  // and how many BUSY cycles the current grant has lasted (1-based).
  int  ph  = 0;   // 0 waiting, 1 serving, 2 gap
  int  age = 0;
  bit  own = 1'b1;
  bit  model_on = 1'b0;

  logic o_m0r, o_m1r, o_tmo, o_sv, o_own;
  logic [31:0] o_m0rd, o_m1rd;

  task automatic cyc();
    logic serving, ov, fin;
    logic [31:0] rsel;
    @(negedge clk);
    o_m0r = m0_ready; o_m1r = m1_ready; o_tmo = timeout_err; o_sv = s_valid; o_own = owner;
    o_m0rd = m0_rdata; o_m1rd = m1_rdata;
    serving = (ph == 1);
    ov      = own ? m1_valid : m0_valid;
    fin     = serving && ov && (s_ready || age == TIMEOUT);
    rsel    = s_ready ? s_rdata : ERR;
    if (model_on) begin
      chk("model s_valid", {31'b0, s_valid}, {31'b0, serving});
      chk("model owner", {31'b0, owner}, {31'b0, own});
      chk("model m0_ready", {31'b0, m0_ready}, {31'b0, fin && !own});
      chk("model m1_ready", {31'b0, m1_ready}, {31'b0, fin && own});
      chk("model m0_rdata", m0_rdata, (fin && !own) ? rsel : 32'h0);
      chk("model m1_rdata", m1_rdata, (fin && own) ? rsel : 32'h0);
      chk("model timeout_err", {31'b0, timeout_err}, {31'b0, fin && !s_ready});
      chk("model s_wstrb", {28'b0, s_wstrb}, serving ? {28'b0, (own ? m1_wstrb : m0_wstrb)} : 32'h0);
      if (serving) begin
        chk("model s_addr", s_addr, own ? m1_addr : m0_addr);
        chk("model s_wdata", s_wdata, own ? m1_wdata : m0_wdata);
      end
    end
    if (reset) begin
      ph = 0; own = 1'b1; age = 0; model_on = 1'b1;
    end else if (ph == 0) begin
      if (m0_valid || m1_valid) begin
        own = (m0_valid && m1_valid) ? !own : m1_valid;
        ph = 1; age = 1;
      end
    end else if (ph == 1) begin
      if (!ov) ph = 0;
      else if (fin) ph = 2;
      else age++;
    end else begin
      ph = 0;
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic rst, m0v, m1v, srdy;
    logic [31:0] srd;
    logic e_sv, e_m0r, e_m1r, e_own, e_tmo;
    logic [31:0] e_m0rd, e_m1rd;
  } vec_t;

  vec_t tbl[17];
  int hit;

  initial begin
    #1000000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1; m0_valid = 0; m1_valid = 0; s_ready = 0; s_rdata = 0;
    m0_addr = 32'h0000_0010; m0_wdata = 0; m0_wstrb = 0;
    m1_addr = 32'h0000_0020; m1_wdata = 0; m1_wstrb = 0;
    cyc(); cyc();
    reset = 0;

    // m0 read, then 4 back-to-back transactions with both masters requesting
    tbl[0]  = '{0,1,0,0,32'h0,        0,0,0,1,0,32'h0,0};
    tbl[1]  = '{0,1,0,0,32'h0,        1,0,0,0,0,32'h0,0};
    tbl[2]  = '{0,1,0,1,32'h1234_5678,1,1,0,0,0,32'h1234_5678,0};
    tbl[3]  = '{0,0,0,0,32'h0,        0,0,0,0,0,32'h0,0};
    tbl[4]  = '{1,0,0,0,32'h0,        0,0,0,0,0,32'h0,0};
    tbl[5]  = '{0,1,1,1,32'hA1,       0,0,0,1,0,32'h0,0};
    tbl[6]  = '{0,1,1,1,32'hA1,       1,1,0,0,0,32'hA1,0};
    tbl[7]  = '{0,1,1,1,32'hA2,       0,0,0,0,0,32'h0,0};
    tbl[8]  = '{0,1,1,1,32'hA2,       0,0,0,0,0,32'h0,0};
    tbl[9]  = '{0,1,1,1,32'hA3,       1,0,1,1,0,32'h0,32'hA3};
    tbl[10] = '{0,1,1,1,32'hA3,       0,0,0,1,0,32'h0,0};
    tbl[11] = '{0,1,1,1,32'hA4,       0,0,0,1,0,32'h0,0};
    tbl[12] = '{0,1,1,1,32'hA4,       1,1,0,0,0,32'hA4,0};
    tbl[13] = '{0,1,1,1,32'hA5,       0,0,0,0,0,32'h0,0};
    tbl[14] = '{0,1,1,1,32'hA5,       0,0,0,0,0,32'h0,0};
    tbl[15] = '{0,1,1,1,32'hA5,       1,0,1,1,0,32'h0,32'hA5};
    tbl[16] = '{0,0,0,0,32'h0,        0,0,0,1,0,32'h0,0};
    for (int i = 0; i < 17; i++) begin
      reset = tbl[i].rst; m0_valid = tbl[i].m0v; m1_valid = tbl[i].m1v;
      s_ready = tbl[i].srdy; s_rdata = tbl[i].srd;
      cyc();
      chk($sformatf("vec%0d s_valid", i), {31'b0, o_sv}, {31'b0, tbl[i].e_sv});
      chk($sformatf("vec%0d m0_ready", i), {31'b0, o_m0r}, {31'b0, tbl[i].e_m0r});
      chk($sformatf("vec%0d m1_ready", i), {31'b0, o_m1r}, {31'b0, tbl[i].e_m1r});
      chk($sformatf("vec%0d owner", i), {31'b0, o_own}, {31'b0, tbl[i].e_own});
      chk($sformatf("vec%0d timeout_err", i), {31'b0, o_tmo}, {31'b0, tbl[i].e_tmo});
      chk($sformatf("vec%0d m0_rdata", i), o_m0rd, tbl[i].e_m0rd);
      chk($sformatf("vec%0d m1_rdata", i), o_m1rd, tbl[i].e_m1rd);
    end
    reset = 0; m0_valid = 0; m1_valid = 0; s_ready = 0;
    cyc();

    // m1 byte write
    m1_valid = 1; m1_addr = 32'h0200_0008; m1_wdata = 32'h41; m1_wstrb = 4'b0001;
    cyc();
    cyc();
    chk("wr s_valid", {31'b0, o_sv}, 32'h1);
    chk("wr s_wstrb", {28'b0, s_wstrb}, 32'h1);
    chk("wr s_wdata", s_wdata, 32'h41);
    chk("wr s_addr", s_addr, 32'h0200_0008);
    s_ready = 1;
    cyc();
    chk("wr m1_ready", {31'b0, o_m1r}, 32'h1);
    chk("wr m0_ready", {31'b0, o_m0r}, 32'h0);
    m1_valid = 0; s_ready = 0; m1_wstrb = 0;
    cyc();

    // hung slave: forced completion on BUSY cycle TIMEOUT
    m0_valid = 1; s_rdata = 32'h5555_AAAA; hit = -1;
    for (int i = 0; i < 150; i++) begin
      cyc();
      if (o_m0r) begin
        hit = i;
        chk("tmo timeout_err", {31'b0, o_tmo}, 32'h1);
        chk("tmo m0_rdata", o_m0rd, ERR);
        break;
      end
    end
    chk("tmo busy cycle", hit, TIMEOUT);
    m0_valid = 0;
    cyc();
    cyc();
    chk("tmo back to idle", {31'b0, o_sv}, 32'h0);

    // s_ready on the last allowed cycle wins over the watchdog
    m0_valid = 1; s_rdata = 32'hCAFE_F00D; hit = -1;
    for (int i = 0; i < 150; i++) begin
      s_ready = (i == TIMEOUT);
      cyc();
      if (o_m0r) begin
        hit = i;
        chk("edge timeout_err", {31'b0, o_tmo}, 32'h0);
        chk("edge m0_rdata", o_m0rd, 32'hCAFE_F00D);
        break;
      end
    end
    chk("edge busy cycle", hit, TIMEOUT);
    m0_valid = 0; s_ready = 0;
    cyc();

    // reset during BUSY cycle 3, then a fresh m1 request
    m1_valid = 1; m1_addr = 32'h0300_0000;
    cyc(); cyc(); cyc();
    reset = 1;
    cyc();
    reset = 0;
    cyc();
    chk("rst s_valid", {31'b0, o_sv}, 32'h0);
    chk("rst owner", {31'b0, o_own}, 32'h1);
    chk("rst m1_ready", {31'b0, o_m1r}, 32'h0);
    s_ready = 1; s_rdata = 32'h0BAD_F00D;
    cyc();
    chk("rst fresh m1_ready", {31'b0, o_m1r}, 32'h1);
    chk("rst fresh m1_rdata", o_m1rd, 32'h0BAD_F00D);
    m1_valid = 0; s_ready = 0;
    cyc();

    // random traffic with occasional hung slave, protocol aborts and resets
    begin
      bit act0, act1, hang;
      act0 = 0; act1 = 0; o_m0r = 0; o_m1r = 0;
      for (int n = 0; n < 3000; n++) begin
        hang = ((n / 400) % 3) == 2;
        if (o_m0r) act0 = 0;
        else if (act0 && $urandom_range(99) == 0) act0 = 0;
        if (o_m1r) act1 = 0;
        else if (act1 && $urandom_range(99) == 0) act1 = 0;
        if (!act0 && $urandom_range(2) == 0) begin
          act0 = 1; m0_addr = $urandom; m0_wdata = $urandom; m0_wstrb = 4'($urandom);
        end
        if (!act1 && $urandom_range(2) == 0) begin
          act1 = 1; m1_addr = $urandom; m1_wdata = $urandom; m1_wstrb = 4'($urandom);
        end
        m0_valid = act0; m1_valid = act1;
        s_ready  = !hang && ($urandom_range(3) == 0);
        s_rdata  = $urandom;
        reset    = ($urandom_range(499) == 0);
        cyc();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
